// File: rtl/m_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_link_pkg
// Description : Constants and types shared by the serial link scrambler
//               (transmit) and descrambler (receive) blocks: link FSM state
//               encoding, LFSR polynomial x^7+x^6+1 taps and width, and the
//               default sync word / seed values both ends must agree on.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package m_link_pkg;

  // LFSR x^7 + x^6 + 1: feedback is s[6] ^ s[5], shifted in at bit 0.
  localparam int LFSR_W      = 7;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 5;

  localparam logic [7:0]        DEF_SYNC_WORD = 8'hA5;
  localparam logic [LFSR_W-1:0] DEF_SEED      = 7'h7F;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    HUNT   = ST_HUNT,
    LOCKED = ST_LOCKED
  } link_state_e;

endpackage
`default_nettype wire

// File: rtl/m_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : m_lfsr_step
// Description : Combinational DW-step advance of the link LFSR. Produces the
//               state after DW shifts and the DW keystream bits generated on
//               the way; keystream bit k is the feedback of the (k+1)th step.
// Ports       : state_in  - current LFSR state
//               state_out - LFSR state after DW steps
//               keystream - DW keystream bits, bit 0 generated first
// Revision    : 1.0 - initial release
// ============================================================================
module m_lfsr_step
  import m_link_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out,
  output logic [DW-1:0]     keystream
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  always_comb begin
    s         = state_in;
    fb        = 1'b0;
    keystream = '0;
    for (int k = 0; k < DW; k++) begin
      fb           = s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO];
      keystream[k] = fb;
      s            = {s[LFSR_W-2:0], fb};
    end
    state_out = s;
  end

endmodule
`default_nettype wire

// File: rtl/m_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : m_descrambler
// Description : Receive-side link descrambler. Hunts for SYNC_CNT consecutive
//               clean sync words, then strips the additive LFSR keystream from
//               each beat, flags even-parity errors and forwards bytes through
//               a single registered output stage. Too many consecutive parity
//               errors, or a resync pulse, drop back to hunting.
// Ports       : clk, rst_n          - clock, async active-low reset
//               resync              - pulse, forces HUNT
//               in_valid/in_ready   - input handshake
//               in_data, in_par     - scrambled byte and its even parity
//               out_valid/out_ready - output handshake
//               out_data            - descrambled byte
//               out_par_err         - parity error flag of the output beat
//               locked              - registered, high while LOCKED
//               err_cnt             - saturating parity error total (LOCKED)
// Revision    : 1.0 - initial release
// ============================================================================
module m_descrambler
  import m_link_pkg::*;
#(
  parameter int                DW        = 8,
  parameter logic [DW-1:0]     SYNC_WORD = DW'(DEF_SYNC_WORD),
  parameter int                SYNC_CNT  = 2,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
  parameter int                ERR_LIMIT = 4,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resync,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_par_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  link_state_e       state, state_nxt;
  logic [3:0]        sync_cnt, sync_cnt_nxt;
  logic [3:0]        err_run, err_run_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_adv;
  logic [DW-1:0]     ks;
  logic              accept;
  logic              par_err;
  logic              is_sync;
  logic              fwd;

  m_lfsr_step #(
    .DW (DW)
  ) u_lfsr_step (
    .state_in  (lfsr),
    .state_out (lfsr_adv),
    .keystream (ks)
  );

  // Single output register: a new beat can enter whenever the register is
  // empty or is being drained in this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign par_err  = ^{in_data, in_par};
  assign is_sync  = (in_data == SYNC_WORD) && !par_err;
  // A beat accepted together with resync is dropped, never forwarded.
  assign fwd      = accept && !resync && (state == LOCKED);

  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    err_run_nxt  = err_run;
    if (resync) begin
      state_nxt    = HUNT;
      sync_cnt_nxt = '0;
      err_run_nxt  = '0;
    end else if (accept) begin
      case (state)
        HUNT: begin
          if (is_sync) begin
            if (sync_cnt + 4'd1 == 4'(SYNC_CNT)) begin
              state_nxt    = LOCKED;
              sync_cnt_nxt = '0;
              err_run_nxt  = '0;
            end else begin
              sync_cnt_nxt = sync_cnt + 4'd1;
            end
          end else begin
            sync_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (par_err) begin
            if (err_run + 4'd1 == 4'(ERR_LIMIT)) begin
              // The beat that hits the limit is still forwarded (fwd).
              state_nxt    = HUNT;
              err_run_nxt  = '0;
              sync_cnt_nxt = '0;
            end else begin
              err_run_nxt = err_run + 4'd1;
            end
          end else begin
            err_run_nxt = '0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      locked   <= 1'b0;
      sync_cnt <= '0;
      err_run  <= '0;
      lfsr     <= SEED;
    end else begin
      state    <= state_nxt;
      locked   <= (state_nxt == LOCKED);
      sync_cnt <= sync_cnt_nxt;
      err_run  <= err_run_nxt;
      // Keystream restarts from SEED on every lock and only moves on
      // beats that are actually descrambled.
      if (state == HUNT && state_nxt == LOCKED) begin
        lfsr <= SEED;
      end else if (fwd) begin
        lfsr <= lfsr_adv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_par_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (fwd) begin
        out_valid   <= 1'b1;
        out_data    <= in_data ^ ks;
        out_par_err <= par_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (fwd && par_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_descrambler
// Description : Self-checking bench for m_descrambler. A driver issues one
//               beat per cycle and runs a sequence-level reference model that
//               pushes expected output beats into a queue; a monitor compares
//               the DUT output stage against the queue head, and a status
//               monitor compares locked / err_cnt against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_descrambler;

  localparam int         SYNC_CNT  = 2;
  localparam int         ERR_LIMIT = 4;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resync;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_par;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_par_err;
  logic        locked;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  m_descrambler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resync      (resync),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_par      (in_par),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_par_err (out_par_err),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t        q[$];
  bit          ksq[$];
  int          checks   = 0;
  int          failures = 0;
  logic        chk_en   = 1'b0;
  logic        m_locked;
  int          m_sync;
  int          m_run;
  logic [15:0] m_errcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Keystream as a bit sequence: b[n] = b[n-7] ^ b[n-6], where the seven
  // bits preceding the first output are the seed bits s[6] .. s[0].
  task automatic restart_ks();
    logic [6:0] seed_v;
    seed_v = 7'h7F;
    ksq.delete();
    for (int i = 6; i >= 0; i--) ksq.push_back(seed_v[i]);
  endtask

  task automatic next_ks(output logic [7:0] b);
    int n;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      n = ksq.size();
      ksq.push_back(ksq[n-7] ^ ksq[n-6]);
      b[k] = ksq[n];
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_sync   = 0;
    m_run    = 0;
    m_errcnt = '0;
    q.delete();
  endtask

  // Applies the link rules to the beat presented in the current cycle; the
  // model variables then describe the state after the coming clock edge.
  task automatic model_step();
    logic       acc;
    logic       e;
    logic [7:0] ks;
    exp_t       x;
    acc = in_valid && in_ready;
    e   = ^{in_data, in_par};
    if (resync) begin
      m_locked = 1'b0;
      m_sync   = 0;
      m_run    = 0;
    end else if (acc) begin
      if (!m_locked) begin
        if (in_data == SYNC && !e) begin
          m_sync++;
          if (m_sync == SYNC_CNT) begin
            m_locked = 1'b1;
            m_sync   = 0;
            m_run    = 0;
            restart_ks();
          end
        end else begin
          m_sync = 0;
        end
      end else begin
        next_ks(ks);
        x.d = in_data ^ ks;
        x.e = e;
        q.push_back(x);
        if (e) begin
          if (m_errcnt != 16'hFFFF) m_errcnt++;
          m_run++;
          if (m_run == ERR_LIMIT) begin
            m_locked = 1'b0;
            m_run    = 0;
            m_sync   = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic [7:0] d, input logic p, input logic v,
                       input logic ordy, input logic rs);
    @(negedge clk);
    in_data   = d;
    in_par    = p;
    in_valid  = v;
    out_ready = ordy;
    resync    = rs;
    #3;
    model_step();
  endtask

  task automatic beat(input logic [7:0] d, input logic bad);
    cycle(d, (^d) ^ bad, 1'b1, 1'b1, 1'b0);
  endtask

  // Output monitor: the queue holds exactly the beats the DUT should be
  // holding in its output register at this point of the cycle.
  initial begin : out_mon
    logic exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && rst_n) begin
        exp_v = (q.size() != 0);
        check("out_valid", out_valid, exp_v);
        check("in_ready", in_ready, !exp_v || out_ready);
        if (out_valid && exp_v) begin
          check("out_data", out_data, q[0].d);
          check("out_par_err", out_par_err, q[0].e);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin : status_mon
    forever begin
      @(posedge clk);
      #1;
      if (chk_en && rst_n) begin
        check("locked", locked, m_locked);
        check("err_cnt", err_cnt, m_errcnt);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] d;
    logic       p;
    rst_n     = 1'b0;
    resync    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_par    = 1'b0;
    out_ready = 1'b1;
    model_reset();

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_par_err", out_par_err, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Lock acquisition, then the first payload with the seed keystream.
    beat(SYNC, 1'b0);
    beat(SYNC, 1'b0);
    beat(8'h40, 1'b0);
    @(posedge clk);
    #1;
    check("first_payload_valid", out_valid, 1);
    check("first_payload_data", out_data, 8'h00);

    // Backpressure with input offered.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      cycle(d, ^d, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      beat(d, 1'b0);
    end

    // Two errors, a clean beat that breaks the streak, then four in a row.
    beat(8'h12, 1'b1);
    beat(8'h34, 1'b1);
    beat(8'h56, 1'b0);
    for (int i = 0; i < 4; i++) beat(8'($urandom), 1'b1);
    @(posedge clk);
    #1;
    check("errs_locked", locked, 0);
    check("errs_err_cnt", err_cnt, 6);

    // Corrupted sync sequence keeps hunting; the next sync locks.
    beat(SYNC, 1'b0);
    beat(8'h3C, 1'b0);
    beat(SYNC, 1'b0);
    @(posedge clk);
    #1;
    check("hunt_after_3c", locked, 0);
    beat(SYNC, 1'b0);
    @(posedge clk);
    #1;
    check("relock", locked, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!m_locked && $urandom_range(0, 3) != 0) d = SYNC;
      else d = 8'($urandom);
      p = ^d;
      if ($urandom_range(0, 7) == 0) p = ~p;
      cycle(d, p, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) == 0));
    end

    // resync mid-stream: the beat offered with it is dropped.
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(SYNC, 1'b0);
    beat(SYNC, 1'b0);
    beat(8'h77, 1'b0);
    cycle(8'h99, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("resync_locked", locked, 0);

    // Asynchronous reset while a beat is pending in the output register.
    beat(SYNC, 1'b0);
    beat(SYNC, 1'b0);
    beat(8'h11, 1'b1);
    @(negedge clk);
    chk_en    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_par_err", out_par_err, 0);
    check("arst_locked", locked, 0);
    check("arst_err_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    chk_en    = 1'b1;

    beat(SYNC, 1'b0);
    beat(SYNC, 1'b0);
    beat(8'h40, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
